// File: rtl/number_lock_param_if.sv
// Button inputs and lock status outputs of the number lock.
// The master side drives the buttons and observes the lock status.
interface number_lock_param_if #(
  parameter int PW = 3,
  parameter int FW = 2
);
  logic          u;
  logic          z;
  logic [2:0]    state;
  logic [PW-1:0] progress;
  logic [FW-1:0] fail_count;
  logic          unlock;
  logic          locked_out;

  modport master (output u, z, input state, progress, fail_count, unlock, locked_out);
  modport slave  (input u, z, output state, progress, fail_count, unlock, locked_out);
endinterface

// File: rtl/number_lock_param.sv
// Parametrised push-button code lock.
// Adds retry counting with lockout, an entry inactivity timeout and a timed unlock pulse.
module number_lock_param #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  OPEN_CYCLES    = 8,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  ENTRY_TIMEOUT  = 32
)(
  input  logic              sysclk,
  input  logic              reset,
  number_lock_param_if.slave bus
);
  localparam int PW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_TRIES + 1);
  localparam int IW   = $clog2(CODE_LEN);
  localparam int TM0  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX = (TM0 > ENTRY_TIMEOUT) ? TM0 : ENTRY_TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    OPEN    = 3'd2,
    BAD     = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t        st;
  logic [PW-1:0] progress;
  logic [FW-1:0] fail_count;
  logic [TW-1:0] timer;
  logic          unlock, locked_out;
  logic          u_q, z_q;

  logic          pu, pz, press, v1, v0, exp_bit, correct;
  logic [FW-1:0] fail_inc;

  // A press that is not a clean single-button rise never matches a digit.
  always_comb begin
    pu       = bus.u & ~u_q;
    pz       = bus.z & ~z_q;
    press    = pu | pz;
    v1       = pu & ~bus.z;
    v0       = pz & ~bus.u;
    exp_bit  = CODE[IW'(CODE_LEN - 1) - IW'(progress)];
    correct  = exp_bit ? v1 : v0;
    fail_inc = (fail_count == FW'(MAX_TRIES)) ? fail_count : fail_count + FW'(1);
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      st         <= IDLE;
      progress   <= '0;
      fail_count <= '0;
      timer      <= '0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      u_q        <= 1'b1;
      z_q        <= 1'b1;
    end else begin
      u_q        <= bus.u;
      z_q        <= bus.z;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      case (st)
        IDLE, ENTRY: begin
          if (press && correct) begin
            timer <= '0;
            if (progress == PW'(CODE_LEN - 1)) begin
              st         <= OPEN;
              progress   <= '0;
              fail_count <= '0;
              unlock     <= 1'b1;
            end else begin
              st       <= ENTRY;
              progress <= progress + PW'(1);
            end
          end else if (press || (st == ENTRY && timer == TW'(ENTRY_TIMEOUT - 1))) begin
            st         <= BAD;
            progress   <= '0;
            fail_count <= fail_inc;
          end else if (st == ENTRY) begin
            timer <= timer + TW'(1);
          end
        end
        OPEN: begin
          if (timer == TW'(OPEN_CYCLES - 1)) begin
            st <= IDLE;
          end else begin
            timer  <= timer + TW'(1);
            unlock <= 1'b1;
          end
        end
        BAD: begin
          if (fail_count == FW'(MAX_TRIES)) begin
            st         <= LOCKOUT;
            timer      <= '0;
            locked_out <= 1'b1;
          end else if (!bus.u && !bus.z) begin
            st <= IDLE;
          end
        end
        LOCKOUT: begin
          if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
            st         <= IDLE;
            fail_count <= '0;
          end else begin
            timer      <= timer + TW'(1);
            locked_out <= 1'b1;
          end
        end
        default: begin
          st       <= IDLE;
          progress <= '0;
        end
      endcase
    end
  end

  assign bus.state      = st;
  assign bus.progress   = progress;
  assign bus.fail_count = fail_count;
  assign bus.unlock     = unlock;
  assign bus.locked_out = locked_out;
endmodule

// File: doc/number_lock_param.md
Name: number_lock_param

Overview:
- Parametrised successor to the fixed 11-state number lock.
- Takes two push-button inputs, u ("one") and z ("zero"), and detects a press of either.
- Matches the presses against a compile-time code of CODE_LEN bits.
- Adds a retry counter with lockout, an entry inactivity timeout, and a timed unlock pulse.
- Sits directly behind the debounced button inputs; drives the unlock actuator and the status display.

Parameters:
- CODE_LEN, 4, number of digits in the code (legal range 2..16).
- CODE, 4'b1011, code value, width CODE_LEN. The MSB is the first digit entered.
- MAX_TRIES, 3, number of bad attempts that triggers lockout (legal range 1..15).
- OPEN_CYCLES, 8, number of cycles unlock is held high (must be at least 1).
- LOCKOUT_CYCLES, 16, number of cycles spent in LOCKOUT (must be at least 1).
- ENTRY_TIMEOUT, 32, number of idle cycles allowed between digits in ENTRY before the attempt counts as bad.

Ports:
- sysclk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on the sysclk rising edge).
- u  in  1  "one" button, level, already debounced.
- z  in  1  "zero" button, level, already debounced.
- state  out  3  current state: IDLE=0, ENTRY=1, OPEN=2, BAD=3, LOCKOUT=4.
- progress  out  clog2(CODE_LEN+1)  number of correct digits entered so far.
- fail_count  out  clog2(MAX_TRIES+1)  number of bad attempts since the last OPEN or LOCKOUT.
- unlock  out  1  high only while in OPEN.
- locked_out  out  1  high only while in LOCKOUT.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; progress, fail_count, the timer, unlock and locked_out all 0.
  - Edge registers u_q and z_q are set to 1, so a button held through reset is not counted as a press.
- Press detection:
  - pu = u & ~u_q; pz = z & ~z_q. u_q and z_q are updated every cycle.
- Digit classification:
  - valid-1: pu & ~z.
  - valid-0: pz & ~u.
  - Any other press (both buttons rising together, or one rising while the other is held) is a wrong digit.
- Latency: a press sampled at edge k takes effect at that same edge. All outputs are registered and reflect the new state after edge k.
- Expected digit: CODE[CODE_LEN-1-progress].
- IDLE:
  - Correct digit: go to ENTRY, progress=1, timer=0.
  - Wrong digit: go to BAD.
  - No press: stay.
- ENTRY:
  - Correct digit: progress+1 and timer=0. If the new progress equals CODE_LEN, go to OPEN instead (progress=0, fail_count=0, timer=0).
  - Wrong digit: go to BAD.
  - No press: timer+1. When the timer reaches ENTRY_TIMEOUT-1 with no press, go to BAD.
- BAD:
  - On entry: fail_count+1 (saturating at MAX_TRIES) and progress=0.
  - If fail_count==MAX_TRIES: go to LOCKOUT on the next edge (timer=0), regardless of the buttons.
  - Otherwise: stay until u==0 and z==0 at an edge, then go to IDLE.
  - Presses while in BAD are ignored.
- OPEN:
  - unlock=1 for exactly OPEN_CYCLES cycles, then go to IDLE.
  - Presses are ignored.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYCLES cycles.
  - On exit, fail_count=0 and go to IDLE.
  - Presses are ignored.
- Timer: one shared counter, width clog2 of the largest of OPEN_CYCLES, LOCKOUT_CYCLES and ENTRY_TIMEOUT. It never wraps.
- Reset asserted in any state returns every register to its reset value at that edge.
- Illegal state encodings (5..7) go to IDLE on the next edge.

Test Plan:
- Defaults; after reset, press u, z, u, u one at a time, each held 2 cycles with 3-cycle gaps -> progress steps 1,2,3. On the 4th press: state=OPEN, unlock=1 for exactly 8 cycles, then state=IDLE; fail_count stays 0.
- Press u, then u (expected 0) -> state=BAD, fail_count=1, held while u=1. Release u -> IDLE on the next edge.
- Three consecutive bad attempts -> on the 3rd: BAD (fail_count=3), then LOCKOUT next edge with locked_out=1 for exactly 16 cycles. A valid sequence entered during lockout is ignored. On exit: IDLE, fail_count=0.
- Press u, then no input for 32 cycles -> BAD with fail_count=1 exactly 32 cycles after the press edge.
- Hold u through reset, then release reset -> no press registered, state stays IDLE. Raise z while u is still held -> BAD.
- Drive reset=0 mid-ENTRY with progress=2 -> next edge: state=IDLE, progress=0, fail_count=0. A fresh 1,0,1,1 sequence then opens the lock.
